vend_change_dispenser: RTL and testbench

//  Sink of the vending controller's change output: converts a change amount in cents into a sequence of coin-eject requests.

---
 rtl/vend_change_dispenser_pkg.sv | 34 +++
 rtl/vend_change_dispenser_if.sv | 29 ++
 rtl/vend_change_dispenser_inventory.sv | 45 ++++
 rtl/vend_change_dispenser.sv | 138 +++++++++++++
 tb/tb_vend_change_dispenser.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin select codes, the
// denomination value table and the controller state encodings.
package vend_change_dispenser_pkg;

  localparam int NUM_DENOM = 6;

  // Coin select codes, largest denomination first
  localparam logic [2:0] SEL_500 = 3'd0;
  localparam logic [2:0] SEL_100 = 3'd1;
  localparam logic [2:0] SEL_25  = 3'd2;
  localparam logic [2:0] SEL_10  = 3'd3;
  localparam logic [2:0] SEL_5   = 3'd4;
  localparam logic [2:0] SEL_1   = 3'd5;

  // Controller states
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_EJECT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Value in cents of a coin select code; unused codes are worth nothing
  function automatic logic [15:0] denom_value(input logic [2:0] code);
    case (code)
      SEL_500: denom_value = 16'd500;
      SEL_100: denom_value = 16'd100;
      SEL_25:  denom_value = 16'd25;
      SEL_10:  denom_value = 16'd10;
      SEL_5:   denom_value = 16'd5;
      SEL_1:   denom_value = 16'd1;
      default: denom_value = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Controller/hopper-facing signal bundle of the change dispenser.
// The slave modport is the dispenser side; the master modport drives it.
interface vend_change_dispenser_if #(
  parameter int AMT_W = 16
);
  import vend_change_dispenser_pkg::*;

  logic                 I_START;
  logic [AMT_W-1:0]     I_AMOUNT;
  logic                 O_BUSY;
  logic                 O_COIN_VALID;
  logic [2:0]           O_COIN_SEL;
  logic                 I_COIN_ACK;
  logic                 O_DONE;
  logic [AMT_W-1:0]     O_SHORT;
  logic                 I_REFILL;
  logic [NUM_DENOM-1:0] O_LOW;

  modport slave (
    input  I_START, I_AMOUNT, I_COIN_ACK, I_REFILL,
    output O_BUSY, O_COIN_VALID, O_COIN_SEL, O_DONE, O_SHORT, O_LOW
  );

  modport master (
    output I_START, I_AMOUNT, I_COIN_ACK, I_REFILL,
    input  O_BUSY, O_COIN_VALID, O_COIN_SEL, O_DONE, O_SHORT, O_LOW
  );

endinterface

// File: rtl/vend_change_dispenser_inventory.sv
// Per-denomination coin counters for the inventory build
// (VEND_CHANGE_INVENTORY_EN). Counts reload on reset and on refill and
// decrement by one for every coin the hopper acknowledges.
module vend_coin_inventory
  import vend_change_dispenser_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 50,
  parameter int LOW_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec,
  input  logic [2:0]           dec_sel,
  input  logic                 refill,
  output logic [NUM_DENOM-1:0] available,
  output logic [NUM_DENOM-1:0] low
);

  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_COUNT);
  localparam logic [CNT_W-1:0] LOW_C  = CNT_W'(LOW_THRESH);

  logic [CNT_W-1:0] cnt [NUM_DENOM];

  // Reload on reset/refill, otherwise count down the acknowledged coin
  always_ff @(posedge clk) begin
    if (rst || refill) begin
      for (int i = 0; i < NUM_DENOM; i++) cnt[i] <= INIT_C;
    end else if (dec) begin
      for (int i = 0; i < NUM_DENOM; i++)
        if (dec_sel == 3'(i) && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
    end
  end

  // Availability and low-stock flags straight from the counts
  always_comb begin
    available = '0;
    low       = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      available[i] = (cnt[i] != '0);
      low[i]       = (cnt[i] <= LOW_C);
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: turns a change amount in cents into greedy,
// largest-coin-first eject requests, one coin per hopper handshake, then
// pulses O_DONE with any undeliverable remainder on O_SHORT.
// Optional feature macro: VEND_CHANGE_INVENTORY_EN (finite coin stock,
// refill and low-stock flags). Without it supply is unlimited.
module vend_change_dispenser
  import vend_change_dispenser_pkg::*;
#(
  parameter int AMT_W      = 16,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 50,
  parameter int LOW_THRESH = 4
) (
  input  logic                   I_CLK,
  input  logic                   I_RESET,
  vend_change_dispenser_if.slave bus
);

  logic [1:0]           state;
  logic [AMT_W-1:0]     remaining;
  logic [AMT_W-1:0]     short_q;
  logic [2:0]           coin_sel;
  logic                 coin_valid;
  logic                 busy;
  logic                 done;
  logic [NUM_DENOM-1:0] avail;
  logic [NUM_DENOM-1:0] low;
  logic                 found;
  logic [2:0]           pick_sel;
  logic [AMT_W-1:0]     coin_val;

  assign coin_val = AMT_W'(denom_value(coin_sel));

`ifdef VEND_CHANGE_INVENTORY_EN
  logic coin_taken;
  logic refill_ok;

  assign coin_taken = (state == S_EJECT) && bus.I_COIN_ACK;
  // Refill only between transactions so counts never jump mid-dispense
  assign refill_ok  = bus.I_REFILL && (state == S_IDLE);

  vend_coin_inventory #(
    .CNT_W      (CNT_W),
    .INIT_COUNT (INIT_COUNT),
    .LOW_THRESH (LOW_THRESH)
  ) u_inventory (
    .clk       (I_CLK),
    .rst       (I_RESET),
    .dec       (coin_taken),
    .dec_sel   (coin_sel),
    .refill    (refill_ok),
    .available (avail),
    .low       (low)
  );
`else
  // Unlimited supply: every coin always available, nothing ever low
  localparam int unused_cfg = CNT_W + INIT_COUNT + LOW_THRESH;
  logic unused_refill;

  assign unused_refill = bus.I_REFILL;
  assign avail         = '1;
  assign low           = '0;
`endif

  // Largest available denomination that still fits in the remainder
  always_comb begin
    found    = 1'b0;
    pick_sel = 3'd0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (avail[i] && (AMT_W'(denom_value(3'(i))) <= remaining)) begin
        found    = 1'b1;
        pick_sel = 3'(i);
      end
    end
  end

  // Transaction sequencer: select a coin, hold it until acked, repeat
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state      <= S_IDLE;
      remaining  <= '0;
      short_q    <= '0;
      coin_sel   <= 3'd0;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (bus.I_START) begin
            remaining <= bus.I_AMOUNT;
            short_q   <= '0;
            busy      <= 1'b1;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remaining == '0) begin
            short_q <= '0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (found) begin
            coin_sel   <= pick_sel;
            coin_valid <= 1'b1;
            state      <= S_EJECT;
          end else begin
            short_q <= remaining;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_EJECT: begin
          // Selected value never exceeds remaining, so no underflow here
          if (bus.I_COIN_ACK) begin
            remaining  <= remaining - coin_val;
            coin_valid <= 1'b0;
            state      <= S_SELECT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.O_BUSY       = busy;
  assign bus.O_COIN_VALID = coin_valid;
  assign bus.O_COIN_SEL   = coin_sel;
  assign bus.O_DONE       = done;
  assign bus.O_SHORT      = short_q;
  assign bus.O_LOW        = low;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: table-driven transactions with a coin
// scoreboard, plus hand-written reset, ignored-input and inventory cases.
module tb_vend_change_dispenser;

`ifdef VEND_CHANGE_INVENTORY_EN
  localparam int TB_INIT = 1;
`else
  localparam int TB_INIT = 50;
`endif

  logic I_CLK = 1'b0;
  logic I_RESET = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [2:0] exp_q[$];
  int         model_cnt[6];
  int         coin_vals[6] = '{500, 100, 25, 10, 5, 1};

  vend_change_dispenser_if #(.AMT_W(16)) bus ();

  vend_change_dispenser #(
    .AMT_W      (16),
    .CNT_W      (8),
    .INIT_COUNT (TB_INIT),
    .LOW_THRESH (4)
  ) dut (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .bus     (bus)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    int  amount;
    bit  tie;
    int  delay;
    bit  inj;
    int  exp_n;
    int  exp_short;
    int  exp_lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) model_cnt[i] = TB_INIT;
  endtask

  // Greedy reference: push the expected coin codes for one amount
  task automatic model_txn(input int amount);
    int  rem;
    bit  hit;
    rem = amount;
    hit = 1'b1;
    while (hit) begin
      hit = 1'b0;
      for (int i = 0; i < 6; i++) begin
`ifdef VEND_CHANGE_INVENTORY_EN
        if (!hit && model_cnt[i] > 0 && coin_vals[i] <= rem) begin
`else
        if (!hit && coin_vals[i] <= rem) begin
`endif
          exp_q.push_back(3'(i));
          rem = rem - coin_vals[i];
          model_cnt[i] = model_cnt[i] - 1;
          hit = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge I_CLK);
    I_RESET = 1'b1;
    @(negedge I_CLK);
    @(negedge I_CLK);
    I_RESET = 1'b0;
    exp_q.delete();
    model_reset();
    chk("rst_busy",  bus.O_BUSY, 0);
    chk("rst_valid", bus.O_COIN_VALID, 0);
    chk("rst_sel",   bus.O_COIN_SEL, 0);
    chk("rst_done",  bus.O_DONE, 0);
    chk("rst_short", bus.O_SHORT, 0);
`ifdef VEND_CHANGE_INVENTORY_EN
    chk("rst_low",   bus.O_LOW, 6'b111111);
`else
    chk("rst_low",   bus.O_LOW, 0);
`endif
  endtask

  // One full transaction; cyc counts cycles since the START cycle
  task automatic run_txn(input vec_t v, input string tag);
    int   cyc, coins, wait_cnt;
    bit   got_done, unstable, quiet;
    logic [2:0] prev_sel, exp_sel;
    model_txn(v.amount);
    @(negedge I_CLK);
    bus.I_START  = 1'b1;
    bus.I_AMOUNT = 16'(v.amount);
    @(negedge I_CLK);
    bus.I_START = 1'b0;
    cyc = 1;
    coins = 0;
    wait_cnt = 0;
    got_done = 1'b0;
    unstable = 1'b0;
    prev_sel = 3'd0;
    chk({tag, "_busy"}, bus.O_BUSY, 1);
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (v.inj && cyc == 3) begin
        bus.I_START  = 1'b1;
        bus.I_AMOUNT = 16'd7;
        bus.I_REFILL = 1'b1;
      end else begin
        bus.I_START  = 1'b0;
        bus.I_REFILL = 1'b0;
      end
      if (bus.O_DONE) begin
        got_done = 1'b1;
        bus.I_COIN_ACK = 1'b0;
        chk({tag, "_latency"}, cyc, v.exp_lat);
        chk({tag, "_short"}, bus.O_SHORT, v.exp_short);
        chk({tag, "_coins"}, coins, v.exp_n);
        chk({tag, "_left_in_queue"}, exp_q.size(), 0);
        chk({tag, "_sel_stable"}, unstable, 0);
      end else if (bus.O_COIN_VALID) begin
        if (wait_cnt > 0 && bus.O_COIN_SEL != prev_sel) unstable = 1'b1;
        prev_sel = bus.O_COIN_SEL;
        if (v.tie || wait_cnt >= v.delay) begin
          bus.I_COIN_ACK = 1'b1;
          coins++;
          wait_cnt = 0;
          if (exp_q.size() == 0) chk({tag, "_extra_coin"}, bus.O_COIN_SEL, 7);
          else begin
            exp_sel = exp_q.pop_front();
            chk({tag, "_sel"}, bus.O_COIN_SEL, exp_sel);
          end
        end else begin
          bus.I_COIN_ACK = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.I_COIN_ACK = v.tie;
        wait_cnt = 0;
      end
      if (!got_done) begin
        @(negedge I_CLK);
        cyc++;
      end
    end
    if (!got_done) chk({tag, "_done_timeout"}, 0, 1);
    bus.I_COIN_ACK = 1'b0;
    bus.I_START    = 1'b0;
    bus.I_REFILL   = 1'b0;
    @(negedge I_CLK);
    chk({tag, "_done_one_cycle"}, bus.O_DONE, 0);
    chk({tag, "_busy_after"}, bus.O_BUSY, 0);
    if (v.inj) begin
      quiet = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (bus.O_COIN_VALID || bus.O_BUSY || bus.O_DONE) quiet = 1'b0;
        @(negedge I_CLK);
      end
      chk({tag, "_no_queued_start"}, quiet, 1);
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   seen;
    bus.I_START    = 1'b0;
    bus.I_AMOUNT   = 16'd0;
    bus.I_COIN_ACK = 1'b0;
    bus.I_REFILL   = 1'b0;
    model_reset();

    do_reset();

`ifdef VEND_CHANGE_INVENTORY_EN
    // One coin of each kind: 200 -> 100,25,10,5,1 and 59 left over
    v = '{amount: 200, tie: 0, delay: 0, inj: 0, exp_n: 5, exp_short: 59, exp_lat: 12};
    run_txn(v, "inv200");
    chk("inv_low", bus.O_LOW, 6'b111111);
    // Refill while idle restores stock, so the same result repeats
    @(negedge I_CLK);
    bus.I_REFILL = 1'b1;
    @(negedge I_CLK);
    bus.I_REFILL = 1'b0;
    model_reset();
    run_txn(v, "refill200");
`else
    vecs[0] = '{amount: 0,     tie: 0, delay: 0, inj: 0, exp_n: 0,   exp_short: 0, exp_lat: 2};
    vecs[1] = '{amount: 641,   tie: 1, delay: 0, inj: 0, exp_n: 6,   exp_short: 0, exp_lat: 14};
    vecs[2] = '{amount: 200,   tie: 0, delay: 3, inj: 0, exp_n: 2,   exp_short: 0, exp_lat: 12};
    vecs[3] = '{amount: 65535, tie: 0, delay: 0, inj: 0, exp_n: 133, exp_short: 0, exp_lat: 268};
    vecs[4] = '{amount: 99,    tie: 0, delay: 1, inj: 0, exp_n: 9,   exp_short: 0, exp_lat: 29};
    vecs[5] = '{amount: 30,    tie: 0, delay: 2, inj: 0, exp_n: 2,   exp_short: 0, exp_lat: 10};
    vecs[6] = '{amount: 641,   tie: 0, delay: 2, inj: 1, exp_n: 6,   exp_short: 0, exp_lat: 26};
    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // ACK while no coin is requested must not start anything
    @(negedge I_CLK);
    bus.I_COIN_ACK = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge I_CLK);
      if (bus.O_BUSY || bus.O_COIN_VALID || bus.O_DONE) seen = 1'b1;
    end
    bus.I_COIN_ACK = 1'b0;
    chk("idle_ack_ignored", seen, 0);

    // Reset while a coin is waiting for ACK abandons the transaction
    @(negedge I_CLK);
    bus.I_START  = 1'b1;
    bus.I_AMOUNT = 16'd641;
    @(negedge I_CLK);
    bus.I_START = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge I_CLK);
      if (bus.O_COIN_VALID) seen = 1'b1;
    end
    chk("rst_mid_valid_seen", seen, 1);
    I_RESET = 1'b1;
    @(negedge I_CLK);
    I_RESET = 1'b0;
    chk("rst_mid_valid_drop", bus.O_COIN_VALID, 0);
    chk("rst_mid_busy_drop", bus.O_BUSY, 0);
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge I_CLK);
      if (bus.O_DONE || bus.O_COIN_VALID) seen = 1'b1;
    end
    chk("rst_mid_no_done", seen, 0);
    exp_q.delete();
    model_reset();
    v = '{amount: 100, tie: 0, delay: 0, inj: 0, exp_n: 1, exp_short: 0, exp_lat: 4};
    run_txn(v, "after_rst");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
